// File: rtl/tick_pkg.sv
// Shared types and helpers for the tick sequencer: FSM/mode encodings and
// the period clamp applied whenever a period is latched.
package tick_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    MODE_FREE    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_e;

  // Limit a requested last-tick index to the deepest tick the sequencer has.
  function automatic int unsigned clamp_period(input int unsigned p,
                                               input int unsigned n_ticks);
    return (p >= n_ticks) ? (n_ticks - 1) : p;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Tick index up-counter with synchronous clear, enable and a terminal
// compare against a caller-supplied limit.
module tick_counter #(
  parameter int unsigned TICK_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [TICK_W-1:0] limit_i,
  output logic [TICK_W-1:0] count_o,
  output logic              at_limit_o
);

  logic [TICK_W-1:0] count_q;
  logic [TICK_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign at_limit_o = (count_q == limit_i);

endmodule

// File: rtl/tick_sequencer.sv
// Per-generation tick phase sequencer: free-run / one-shot tick counting with
// programmable period, stall, one-hot phase decode, wrap/done pulses and epoch count.
module tick_sequencer
  import tick_pkg::*;
#(
  parameter int unsigned N_TICKS = 8,
  parameter int unsigned EPOCH_W = 16,
  localparam int unsigned TICK_W = $clog2(N_TICKS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [TICK_W-1:0]  period,
  output logic [TICK_W-1:0]  tick_out,
  output logic [N_TICKS-1:0] tick_onehot,
  output logic               last_tick,
  output logic               wrap,
  output logic               done,
  output logic               busy,
  output logic [EPOCH_W-1:0] epoch
);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [TICK_W-1:0]  period_q, period_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;

  logic               cnt_clr;
  logic               cnt_en;
  logic               at_limit;
  logic [TICK_W-1:0]  tick_q;
  logic [TICK_W-1:0]  period_clamped;

  assign period_clamped = TICK_W'(clamp_period(32'(period), N_TICKS));

  tick_counter #(
    .TICK_W(TICK_W)
  ) u_cnt (
    .clk_i     (clk),
    .rst_i     (rst),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .limit_i   (period_q),
    .count_o   (tick_q),
    .at_limit_o(at_limit)
  );

  // Priority: stop, then start (restart), then the enabled advance/terminal step.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    period_d = period_q;
    epoch_d  = epoch_q;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      cnt_clr = 1'b1;
    end else if (start) begin
      state_d  = S_RUN;
      period_d = period_clamped;
      mode_d   = mode_e'(mode);
      cnt_clr  = 1'b1;
    end else if (state_q == S_RUN && ena) begin
      if (at_limit) begin
        cnt_clr = 1'b1;
        epoch_d = epoch_q + EPOCH_W'(1);
        if (mode_q == MODE_FREE) begin
          wrap_d   = 1'b1;
          period_d = period_clamped;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end else begin
        cnt_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_FREE;
      period_q <= '0;
      epoch_q  <= '0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      epoch_q  <= epoch_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    tick_onehot = '0;
    for (int unsigned i = 0; i < N_TICKS; i++) begin
      tick_onehot[i] = busy && (tick_q == TICK_W'(i));
    end
  end

  assign busy      = (state_q == S_RUN);
  assign tick_out  = tick_q;
  assign last_tick = busy && at_limit;
  assign wrap      = wrap_q;
  assign done      = done_q;
  assign epoch     = epoch_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer: an 8-tick instance checked against a
// vector table, plus a 6-tick / 2-bit-epoch instance for clamp and rollover.
module tb_tick_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] period = 3'd0;

  logic [2:0]  t8;
  logic [7:0]  oh8;
  logic        last8, wrap8, done8, busy8;
  logic [15:0] ep8;

  logic [2:0]  t6;
  logic [5:0]  oh6;
  logic        last6, wrap6, done6, busy6;
  logic [1:0]  ep6;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tick_sequencer #(.N_TICKS(8), .EPOCH_W(16)) dut8 (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop), .mode(mode),
    .period(period), .tick_out(t8), .tick_onehot(oh8), .last_tick(last8),
    .wrap(wrap8), .done(done8), .busy(busy8), .epoch(ep8)
  );

  tick_sequencer #(.N_TICKS(6), .EPOCH_W(2)) dut6 (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop), .mode(mode),
    .period(period), .tick_out(t6), .tick_onehot(oh6), .last_tick(last6),
    .wrap(wrap6), .done(done6), .busy(busy6), .epoch(ep6)
  );

  typedef struct {
    logic        rst, ena, start, stop, mode;
    logic [2:0]  period;
    logic [2:0]  tick;
    logic        busy, wrap, done, last;
    logic [15:0] epoch;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic s, input logic p,
                     input logic m, input logic [2:0] per, input logic [2:0] tk,
                     input logic b, input logic w, input logic d, input logic l,
                     input logic [15:0] ep);
    vec_t v;
    v.rst = r; v.ena = e; v.start = s; v.stop = p; v.mode = m; v.period = per;
    v.tick = tk; v.busy = b; v.wrap = w; v.done = d; v.last = l; v.epoch = ep;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic s, input logic p,
                      input logic m, input logic [2:0] per);
    rst = r; ena = e; start = s; stop = p; mode = m; period = per;
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [2:0] tk, input logic b,
                        input logic w, input logic d, input logic l, input logic [15:0] ep);
    logic [7:0] oh;
    oh = b ? (8'd1 << tk) : 8'd0;
    chk({tag, ".tick"},   32'(t8),    32'(tk));
    chk({tag, ".busy"},   32'(busy8), 32'(b));
    chk({tag, ".wrap"},   32'(wrap8), 32'(w));
    chk({tag, ".done"},   32'(done8), 32'(d));
    chk({tag, ".last"},   32'(last8), 32'(l));
    chk({tag, ".epoch"},  32'(ep8),   32'(ep));
    chk({tag, ".onehot"}, 32'(oh8),   32'(oh));
  endtask

  task automatic check6(input string tag, input logic [2:0] tk, input logic b,
                        input logic w, input logic [1:0] ep);
    logic [5:0] oh;
    oh = b ? (6'd1 << tk) : 6'd0;
    chk({tag, ".tick6"},   32'(t6),    32'(tk));
    chk({tag, ".busy6"},   32'(busy6), 32'(b));
    chk({tag, ".wrap6"},   32'(wrap6), 32'(w));
    chk({tag, ".epoch6"},  32'(ep6),   32'(ep));
    chk({tag, ".onehot6"}, 32'(oh6),   32'(oh));
  endtask

  initial begin
    // reset, then free-run period 7 for 20 visible ticks
    add(1,0,0,0,0,3'd0, 3'd0,0,0,0,0,16'd0);
    add(0,1,1,0,0,3'd7, 3'd0,1,0,0,0,16'd0);
    for (int i = 1; i < 20; i++)
      add(0,1,0,0,0,3'd7, 3'(i % 8),1,(i % 8 == 0),0,(i % 8 == 7),16'(i / 8));
    add(0,1,0,1,0,3'd7, 3'd0,0,0,0,0,16'd2);
    add(0,1,0,0,0,3'd7, 3'd0,0,0,0,0,16'd2);
    // one-shot period 3; period input changes must not matter after start
    add(1,0,0,0,0,3'd0, 3'd0,0,0,0,0,16'd0);
    add(0,1,1,0,1,3'd3, 3'd0,1,0,0,0,16'd0);
    add(0,1,0,0,1,3'd6, 3'd1,1,0,0,0,16'd0);
    add(0,1,0,0,1,3'd6, 3'd2,1,0,0,0,16'd0);
    add(0,1,0,0,1,3'd6, 3'd3,1,0,0,1,16'd0);
    add(0,1,0,0,1,3'd6, 3'd0,0,0,1,0,16'd1);
    add(0,1,0,0,1,3'd6, 3'd0,0,0,0,0,16'd1);
    add(0,1,0,0,1,3'd6, 3'd0,0,0,0,0,16'd1);
    // stall, free-run period 5
    add(0,1,1,0,0,3'd5, 3'd0,1,0,0,0,16'd1);
    add(0,1,0,0,0,3'd5, 3'd1,1,0,0,0,16'd1);
    add(0,0,0,0,0,3'd5, 3'd1,1,0,0,0,16'd1);
    add(0,0,0,0,0,3'd5, 3'd1,1,0,0,0,16'd1);
    add(0,1,0,0,0,3'd5, 3'd2,1,0,0,0,16'd1);
    add(0,1,0,0,0,3'd5, 3'd3,1,0,0,0,16'd1);
    add(0,1,0,0,0,3'd5, 3'd4,1,0,0,0,16'd1);
    add(0,1,0,0,0,3'd5, 3'd5,1,0,0,1,16'd1);
    add(0,0,0,0,0,3'd5, 3'd5,1,0,0,1,16'd1);
    add(0,1,0,0,0,3'd5, 3'd0,1,1,0,0,16'd2);
    // restart while running with period 0
    add(0,1,1,0,0,3'd0, 3'd0,1,0,0,1,16'd2);
    add(0,1,0,0,0,3'd0, 3'd0,1,1,0,1,16'd3);
    add(0,1,0,0,0,3'd0, 3'd0,1,1,0,1,16'd4);
    add(0,0,0,0,0,3'd0, 3'd0,1,0,0,1,16'd4);
    add(0,1,0,0,0,3'd0, 3'd0,1,1,0,1,16'd5);
    // period re-sampled at a free-run wrap
    add(0,1,0,0,0,3'd2, 3'd0,1,1,0,0,16'd6);
    add(0,1,0,0,0,3'd2, 3'd1,1,0,0,0,16'd6);
    add(0,1,0,0,0,3'd2, 3'd2,1,0,0,1,16'd6);
    add(0,1,0,0,0,3'd2, 3'd0,1,1,0,0,16'd7);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ena, vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].period);
      check8($sformatf("vec%0d", i), vecs[i].tick, vecs[i].busy, vecs[i].wrap,
             vecs[i].done, vecs[i].last, vecs[i].epoch);
    end

    // clamp on the 6-tick instance: period 7 runs 0..5
    step(1,0,0,0,0,3'd0);
    step(0,1,1,0,0,3'd7);
    check6("clamp_start", 3'd0, 1, 0, 2'd0);
    for (int i = 1; i <= 5; i++) begin
      step(0,1,0,0,0,3'd7);
      check6($sformatf("clamp%0d", i), 3'(i), 1, 0, 2'd0);
    end
    chk("clamp_last", 32'(last6), 32'd1);
    step(0,1,0,0,0,3'd7);
    check6("clamp_wrap", 3'd0, 1, 1, 2'd1);

    // 2-bit epoch rollover with period 0
    step(1,0,0,0,0,3'd0);
    step(0,1,1,0,0,3'd0);
    check6("roll_start", 3'd0, 1, 0, 2'd0);
    for (int i = 1; i <= 5; i++) begin
      step(0,1,0,0,0,3'd0);
      check6($sformatf("roll%0d", i), 3'd0, 1, 1, 2'(i % 4));
    end

    // start and stop together: stop wins, from RUN and from IDLE
    step(0,1,1,1,0,3'd4);
    check8("startstop_run", 3'd0, 0, 0, 0, 0, 16'd5);
    step(0,1,1,1,0,3'd4);
    check8("startstop_idle", 3'd0, 0, 0, 0, 0, 16'd5);

    // start at last_tick: restart with no wrap and no epoch step
    step(1,0,0,0,0,3'd0);
    step(0,1,1,0,0,3'd3);
    for (int i = 0; i < 3; i++) step(0,1,0,0,0,3'd3);
    check8("atlast_pre", 3'd3, 1, 0, 0, 1, 16'd0);
    step(0,1,1,0,0,3'd3);
    check8("atlast_start", 3'd0, 1, 0, 0, 0, 16'd0);
    // same in one-shot: no done
    step(0,1,1,0,1,3'd1);
    step(0,1,0,0,1,3'd1);
    check8("os_atlast_pre", 3'd1, 1, 0, 0, 1, 16'd0);
    step(0,1,1,0,1,3'd1);
    check8("os_atlast_start", 3'd0, 1, 0, 0, 0, 16'd0);

    // reset mid-run at tick 4 with a nonzero epoch
    step(0,1,1,0,0,3'd0);
    step(0,1,0,0,0,3'd0);
    step(0,1,0,0,0,3'd0);
    check8("rst_pre_ep", 3'd0, 1, 1, 0, 1, 16'd2);
    step(0,1,1,0,0,3'd7);
    for (int i = 0; i < 4; i++) step(0,1,0,0,0,3'd7);
    check8("rst_pre", 3'd4, 1, 0, 0, 0, 16'd2);
    step(1,1,0,0,0,3'd7);
    check8("rst_mid", 3'd0, 0, 0, 0, 0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_sequencer.md
Name: tick_sequencer

Overview:
- Parametrised successor to the fixed 3-bit tick timer in the life circuit. Generates the per-generation tick phase that sequences cell update steps.
- Adds the following over the fixed timer:
  - configurable maximum depth
  - runtime-programmable period
  - enable/stall
  - free-run and one-shot modes with start/stop control
  - one-hot phase decode
  - wrap/done pulses
  - a generation (epoch) counter
- Sits between the board controller and the cell-array update logic.

Parameters:
- N_TICKS, 8, maximum ticks per generation (>=2). Local TICK_W = $clog2(N_TICKS).
- EPOCH_W, 16, width of the generation counter.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  advance enable; 0 stalls the count (all state held).
- start  in  1  pulse: latch period and mode, clear tick to 0, enter RUN.
- stop  in  1  pulse: abort to IDLE.
- mode  in  1  0 = free-run (wrap forever), 1 = one-shot (single pass, then IDLE).
- period  in  TICK_W  index of last tick (run length = period+1). Sampled only at start and at each free-run wrap.
- tick_out  out  TICK_W  current tick index.
- tick_onehot  out  N_TICKS  one-hot decode of tick_out while busy; all-zero in IDLE.
- last_tick  out  1  busy && tick_out == latched period (combinational from registers).
- wrap  out  1  one-cycle pulse, registered: free-run has just wrapped to tick 0.
- done  out  1  one-cycle pulse, registered: one-shot pass has just completed.
- busy  out  1  FSM in RUN.
- epoch  out  EPOCH_W  count of completed passes (wraps plus one-shot completions), modulo 2^EPOCH_W.

Behaviour:
- Reset (rst=1 at posedge), highest priority:
  - state IDLE; tick_out=0, period_q=0, mode_q=0, epoch=0.
  - wrap=0, done=0, busy=0, tick_onehot=0.
- Period clamp: a latched period >= N_TICKS is clamped to N_TICKS-1. This only matters when N_TICKS is not a power of 2.
- FSM states: IDLE, RUN.
- IDLE:
  - tick_out held at 0; ena ignored.
  - start=1 (and stop=0) -> RUN next cycle, with tick_out=0, period_q=clamp(period), mode_q=mode.
- RUN with ena=1, tick_out != period_q: tick_out+1 next cycle.
- RUN with ena=1, tick_out == period_q (last_tick):
  - Free-run:
    - next cycle tick_out=0, wrap=1.
    - epoch+1; period_q re-sampled from period.
    - remain RUN.
  - One-shot:
    - next cycle IDLE, tick_out=0, done=1, epoch+1.
- RUN with ena=0: everything held; wrap and done are 0.
- Latency:
  - start to first tick 0 visible with busy=1: 1 cycle.
  - A free-run pass takes exactly period+1 enabled cycles.
- period_q=0: last_tick is constantly 1 while busy.
  - Free-run: wrap every enabled cycle.
  - One-shot: done 1 cycle after start.
- start while RUN: restart (tick 0, re-latch period and mode); no wrap, no done, epoch unchanged.
- start and last_tick with ena in the same cycle: start wins (restart, no wrap/done/epoch increment).
- stop:
  - Any state -> IDLE next cycle, tick_out=0, no done.
  - stop and start in the same cycle: stop wins.
- wrap and done are never both 1. Each is a 1-cycle pulse, deasserted the following cycle.
- epoch rolls over from all-ones to 0 silently.
- tick_onehot[i] = busy && tick_out==i.

Decomposition:
- Package tick_pkg holds:
  - state enum (S_IDLE, S_RUN)
  - mode enum (MODE_FREE, MODE_ONESHOT)
  - clamp helper function
- Sub-module tick_counter(TICK_W): up-counter with synchronous clear, enable, and terminal-compare output against a limit input.
- The FSM, latching, pulse generation and epoch counter live in tick_sequencer.

Test Plan:
- N_TICKS=8, free-run: rst, start with period=7, ena=1 for 20 cycles.
  - Required: tick_out 0..7,0..7,0..3.
  - wrap high exactly on the two cycles tick_out returns to 0; epoch=2.
- One-shot: start with period=3, mode=1, ena=1.
  - Required: tick_out 0,1,2,3; then busy=0, done=1 for one cycle, tick_out=0, epoch=1.
  - Further ena produces no change.
- Stall: free-run, period=5; toggle ena 1,0,0,1.
  - Required: tick_out advances only on ena=1 cycles; wrap never asserted during an ena=0 cycle.
- Period boundaries:
  - period=0 free-run: wrap=1 every enabled cycle, tick_onehot=8'b0000_0001.
  - N_TICKS=6 with period=7: clamped to 5, giving sequence 0..5.
- Control collisions:
  - start and stop in the same cycle -> IDLE.
  - start at last_tick -> tick_out=0 with wrap=0 and epoch unchanged.
  - rst mid-RUN at tick 4 -> all outputs 0 next cycle.
- Epoch rollover: EPOCH_W=2, period=0 free-run for 5 cycles -> epoch 1,2,3,0,1.
